result_collector: RTL and testbench



---
 rtl/result_collector.sv | 98 +++++++++
 tb/tb_result_collector.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// Result collector: buffers {data16,data32} beats in a FIFO, keeps a running
// checksum of accepted beats, and drains on a flush command.
module result_collector #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data16,
    input  logic [31:0]   in_data32,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [47:0]   out_data,
    input  logic          flush,
    output logic          done,
    output logic [CW-1:0] count,
    output logic [31:0]   checksum,
    output logic [7:0]    drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [7:0] {
        RUN   = 8'd0,
        FLUSH = 8'd1,
        DONE  = 8'd2
    } state_t;

    state_t fsmState, nextState;

    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    assign in_ready  = (fsmState == RUN) && (count < FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        nextState = fsmState;
        done      = 1'b0;
        unique case (fsmState)
            RUN: begin
                if (flush) nextState = FLUSH;
            end
            FLUSH: begin
                // Last entry leaving this cycle counts as drained.
                if (count == '0 || (count == CW'(1) && pop))
                    nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = RUN;
            end
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fsmState <= RUN;
        else       fsmState <= nextState;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            checksum   <= '0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (fsmState == DONE)
                checksum <= '0;
            else if (push)
                checksum <= checksum + {16'h0, in_data16} + in_data32;
            if (in_valid && !in_ready && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    // Storage needs no reset; out_data is ignored while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_data16, in_data32};
    end

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: table-driven single-beat checks,
// a scoreboard on FIFO order, and hand-written flush/reset sequences.
module tb_result_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data16;
    logic [31:0] in_data32;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic        flush;
    logic        done;
    logic [2:0]  count;
    logic [31:0] checksum;
    logic [7:0]  drop_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [47:0] q[$];
    logic [31:0] exp_sum;

    typedef struct {
        logic [15:0] d16;
        logic [31:0] d32;
        logic [31:0] sum;
    } vec_t;
    vec_t tbl[3];

    result_collector dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data16(in_data16), .in_data32(in_data32),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .done(done),
        .count(count), .checksum(checksum), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle; scoreboard samples handshakes at mid-cycle.
    task automatic step(input logic iv, input logic [15:0] a,
                        input logic [31:0] b, input logic ordy,
                        input logic fl);
        in_valid  = iv;
        in_data16 = a;
        in_data32 = b;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got %0h expected none", out_data);
            end else begin
                chk("sb_data", out_data, q.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            q.push_back({in_data16, in_data32});
            exp_sum = exp_sum + {16'h0, in_data16} + in_data32;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] a;
        logic [31:0] b;
        exp_sum   = 32'h0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data16 = '0;
        in_data32 = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #12 reset = 1'b0;
        @(posedge clk);
        #1;

        chk("rst_count", count, 0);
        chk("rst_sum", checksum, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_done", done, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_iready", in_ready, 1);

        tbl[0] = '{16'h007B, 32'h0000_0001, 32'h0000_007C};
        tbl[1] = '{16'hFFFF, 32'h0000_0010, 32'h0001_008B};
        tbl[2] = '{16'h0001, 32'hFFFF_FF00, 32'h0000_FF8C};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, tbl[i].d16, tbl[i].d32, 1'b0, 1'b0);
            chk("tbl_count", count, 1);
            chk("tbl_sum", checksum, tbl[i].sum);
            chk("tbl_data", out_data, {tbl[i].d16, tbl[i].d32});
            step(1'b0, '0, '0, 1'b1, 1'b0);
            chk("tbl_pop_count", count, 0);
        end

        // Flush of an empty FIFO: one FLUSH cycle, then DONE.
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("f0_iready", in_ready, 0);
        chk("f0_done_early", done, 0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("f0_done", done, 1);
        chk("f0_sum_hold", checksum, 32'h0000_FF8C);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("f0_done_off", done, 0);
        chk("f0_sum_clr", checksum, 0);
        chk("f0_iready_back", in_ready, 1);

        step(1'b1, 16'h0002, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("wrap_sum", checksum, 32'h0000_0001);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("wrap_pop", count, 0);

        // Fill, stall, then stream push+pop.
        exp_sum = 32'h0000_0001;
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'h0010 + 16'(i), 32'h1000_0000 * (i + 1), 1'b0, 1'b0);
        chk("full_count", count, 4);
        chk("full_iready", in_ready, 0);
        chk("full_ovalid", out_valid, 1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'h00AA, 32'h5555_0005, 1'b0, 1'b0);
        chk("stall_drop", drop_count, 3);
        chk("stall_count", count, 4);
        step(1'b1, 16'h00AA, 32'h5555_0005, 1'b1, 1'b0);
        chk("fullpop_drop", drop_count, 4);
        chk("fullpop_count", count, 3);
        chk("fullpop_iready", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            a = (i == 0) ? 16'h00AA : 16'h0100 + 16'(i);
            b = (i == 0) ? 32'h5555_0005 : 32'hA000_0000 + 32'(i * 3);
            step(1'b1, a, b, 1'b1, 1'b0);
            chk("stream_count", count, 3);
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_count", count, 0);
        chk("drain_sb", q.size(), 0);
        chk("drain_sum", checksum, exp_sum);
        chk("drain_drop", drop_count, 4);

        // Three beats, the last pushed in the flush cycle.
        step(1'b1, 16'h0001, 32'h0000_0100, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 32'h0000_0200, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 32'h0000_0300, 1'b0, 1'b1);
        chk("f3_count", count, 3);
        chk("f3_iready", in_ready, 0);
        chk("f3_done0", done, 0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("f3_done1", done, 0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("f3_done2", done, 0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("f3_done", done, 1);
        chk("f3_empty", count, 0);
        chk("f3_sum_hold", checksum, exp_sum);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("f3_done_off", done, 0);
        chk("f3_sum_clr", checksum, 0);
        chk("f3_iready_back", in_ready, 1);
        chk("f3_sb", q.size(), 0);
        exp_sum = 32'h0;

        // Reset while flushing with two entries held.
        step(1'b1, 16'h0BAD, 32'h0000_0001, 1'b0, 1'b0);
        step(1'b1, 16'h0BAD, 32'h0000_0002, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("rf_count_pre", count, 2);
        #2 reset = 1'b1;
        #1;
        chk("rf_count", count, 0);
        chk("rf_ovalid", out_valid, 0);
        chk("rf_sum", checksum, 0);
        chk("rf_drop", drop_count, 0);
        chk("rf_done", done, 0);
        #2 reset = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        chk("rf_iready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            chk("rf_no_done", done, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
